// File: rtl/wb_mem_bist_master_if.sv
// Wishbone classic single-beat bus bundle between the BIST initiator and the memory under test.
// The master modport is the initiator side; the slave modport is the responder side.
interface wb_mem_bist_master_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_mem_bist_master.sv
// Wishbone memory BIST initiator: writes pattern+i to every word, then reads back and compares.
// Optional ack watchdog is enabled by defining MEM_BIST_TIMEOUT_EN.
module wb_mem_bist_master #(
  parameter int unsigned ADR_WIDTH      = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic [31:0]            pattern_i,
  input  logic [ADR_WIDTH:0]     num_words_i,
  wb_mem_bist_master_if.master   wbm,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [15:0]            err_count_o,
  output logic [ADR_WIDTH-1:0]   fail_idx_o,
  output logic                   timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WGAP,
    RD,
    RGAP,
    DONE
  } state_e;

  localparam logic [ADR_WIDTH:0] MaxWords = {1'b1, {ADR_WIDTH{1'b0}}};

  // A zero limit would abort every transfer before any responder could answer.
  if (TIMEOUT_CYCLES == 0) begin : gZeroTimeoutLimit
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                 state_q;
  logic [ADR_WIDTH-1:0]   idx_q;
  logic [ADR_WIDTH-1:0]   lastIdx_q;
  logic [31:0]            pattern_q;
  logic [31:0]            adr_q;
  logic [31:0]            dat_q;
  logic [3:0]             sel_q;
  logic                   we_q;
  logic                   cyc_q;
  logic                   stb_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [15:0]            errCount_q;
  logic [ADR_WIDTH-1:0]   failIdx_q;

  logic [ADR_WIDTH:0]     numClamped;
  logic [ADR_WIDTH-1:0]   lastIdx_d;
  logic [ADR_WIDTH-1:0]   idxInc;
  logic [15:0]            errCount_d;
  logic                   ackSeen;
  logic                   mismatch;
  logic                   wdogExpired;

  function automatic logic [31:0] wordAddr(input logic [ADR_WIDTH-1:0] idx);
    return BASE_ADDR + (32'(idx) << 2);
  endfunction

  function automatic logic [31:0] expData(input logic [ADR_WIDTH-1:0] idx);
    return pattern_q + 32'(idx);
  endfunction

  // The low bits of a full-size count are zero, so subtracting one wraps to the top index.
  assign numClamped = (num_words_i > MaxWords) ? MaxWords : num_words_i;
  assign lastIdx_d  = numClamped[ADR_WIDTH-1:0] - ADR_WIDTH'(1);
  assign idxInc     = idx_q + ADR_WIDTH'(1);
  assign errCount_d = (errCount_q == 16'hFFFF) ? 16'hFFFF : errCount_q + 16'd1;
  assign ackSeen    = wbm.wbm_ack_i && stb_q;
  assign mismatch   = (wbm.wbm_dat_i != expData(idx_q));

`ifdef MEM_BIST_TIMEOUT_EN
  localparam int unsigned WdogW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WdogW-1:0] wdog_q;
  logic             timeout_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !stb_q || ackSeen) begin
      wdog_q <= '0;
    end else if (!wdogExpired) begin
      wdog_q <= wdog_q + WdogW'(1);
    end
  end

  assign wdogExpired = (wdog_q == WdogW'(TIMEOUT_CYCLES));
  assign timeout_o   = timeout_q;
`else
  assign wdogExpired = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lastIdx_q  <= '0;
      pattern_q  <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCount_q <= '0;
      failIdx_q  <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            pattern_q  <= pattern_i;
            lastIdx_q  <= lastIdx_d;
            idx_q      <= '0;
            errCount_q <= '0;
            failIdx_q  <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            if (numClamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WR;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= 4'hF;
              adr_q   <= BASE_ADDR;
              dat_q   <= pattern_i;
            end
          end
        end

        WR, RD: begin
          if (ackSeen) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            if (state_q == WR) begin
              state_q <= WGAP;
            end else begin
              if (mismatch) begin
                errCount_q <= errCount_d;
                if (errCount_q == '0) begin
                  failIdx_q <= idx_q;
                end
              end
              if (idx_q == lastIdx_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= !mismatch && (errCount_q == '0);
              end else begin
                state_q <= RGAP;
              end
            end
          end else if (wdogExpired) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
          end
        end

        // The gap cycle keeps a registered-ack responder from acking the next strobe twice.
        WGAP: begin
          cyc_q <= 1'b1;
          stb_q <= 1'b1;
          sel_q <= 4'hF;
          if (idx_q == lastIdx_q) begin
            state_q <= RD;
            idx_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= BASE_ADDR;
            dat_q   <= '0;
          end else begin
            state_q <= WR;
            idx_q   <= idxInc;
            we_q    <= 1'b1;
            adr_q   <= wordAddr(idxInc);
            dat_q   <= expData(idxInc);
          end
        end

        RGAP: begin
          state_q <= RD;
          idx_q   <= idxInc;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= 1'b0;
          sel_q   <= 4'hF;
          adr_q   <= wordAddr(idxInc);
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = errCount_q;
  assign fail_idx_o  = failIdx_q;

endmodule
